// File: rtl/median_ctrl_pkg.sv
// Shared types and constants for the 3x3 median window controller.
// No logic; imported by the controller and its sub-modules.
package median_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int TAPS    = 9;
    localparam int COORD_W = 16;

endpackage

// File: rtl/median_line_buffer.sv
// One image line of pixels: combinational read of the old value, write on the clock edge (read-before-write).
// No backpressure; the caller gates we_i with the pixel transfer.
module median_line_buffer #(
    parameter int SIZE  = 8,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [SIZE-1:0] wdat_i,
    output logic [SIZE-1:0] rdat_o
);

    logic [SIZE-1:0] mem [WIDTH];

    assign rdat_o = mem[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdat_i;
        end
    end

endmodule

// File: rtl/median_window_ctrl.sv
// Raster pixels in, 3x3 windows to the sort unit, medians out SORT_LAT+1 edges after the launching transfer.
// pix_ready drops outside FILL/RUN; define MEDIAN_COORD_EN to add med_x/med_y centre coordinates.
module median_window_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int SIZE     = 8,
    parameter int WIDTH    = 64,
    parameter int HEIGHT   = 64,
    parameter int SORT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [SIZE-1:0]      pix_data,
    output logic [TAPS*SIZE-1:0] sort_win,
    input  logic [SIZE-1:0]      sort_median,
    output logic                 med_valid,
    output logic [SIZE-1:0]      med_data
`ifdef MEDIAN_COORD_EN
    ,
    output logic [COORD_W-1:0]   med_x,
    output logic [COORD_W-1:0]   med_y
`endif
);

    localparam int AW = $clog2(WIDTH);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] TWO    = COORD_W'(2);

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic [SIZE-1:0]      win_q [TAPS];
    logic [SORT_LAT:0]    vpipe_q, vpipe_d;
    logic                 med_valid_q;
    logic [SIZE-1:0]      med_data_q;
    logic                 done_q, done_d;
    logic                 xfer, launch, last_pix;
    logic [SIZE-1:0]      lb0_rd, lb1_rd;

    assign pix_ready = (state_q == FILL) || (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign med_valid = med_valid_q;
    assign med_data  = med_data_q;

    assign xfer     = pix_valid && pix_ready;
    assign last_pix = xfer && (x_q == X_LAST) && (y_q == Y_LAST);
    assign launch   = (state_q == RUN) && xfer && (x_q >= TWO) && (y_q >= TWO);

    // lb0 holds the previous line, lb1 the one before; lb1 is fed from lb0's old value
    median_line_buffer #(.SIZE(SIZE), .WIDTH(WIDTH), .AW(AW)) u_lb0 (
        .clk    (clk),
        .we_i   (xfer),
        .addr_i (x_q[AW-1:0]),
        .wdat_i (pix_data),
        .rdat_o (lb0_rd)
    );

    median_line_buffer #(.SIZE(SIZE), .WIDTH(WIDTH), .AW(AW)) u_lb1 (
        .clk    (clk),
        .we_i   (xfer),
        .addr_i (x_q[AW-1:0]),
        .wdat_i (lb0_rd),
        .rdat_o (lb1_rd)
    );

    always_comb begin
        sort_win = '0;
        for (int i = 0; i < TAPS; i++) begin
            sort_win[(TAPS-1-i)*SIZE +: SIZE] = win_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        vpipe_d = {vpipe_q[SORT_LAT-1:0], launch};
        if (xfer) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + ONE;
            end else begin
                x_d = x_q + ONE;
            end
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    x_d     = '0;
                    y_d     = '0;
                    vpipe_d = '0;
                end
            end
            FILL: begin
                if (xfer && (x_q == ONE) && (y_q == TWO)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_pix) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // the final launch is the only bit left once the pipe empties behind it
                if (med_valid_q && (vpipe_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            vpipe_q     <= '0;
            med_valid_q <= 1'b0;
            med_data_q  <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vpipe_q     <= vpipe_d;
            done_q      <= done_d;
            med_valid_q <= vpipe_q[SORT_LAT];
            if (vpipe_q[SORT_LAT]) begin
                med_data_q <= sort_median;
            end
            if (xfer) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r*3]   <= win_q[r*3+1];
                    win_q[r*3+1] <= win_q[r*3+2];
                end
                win_q[2] <= lb1_rd;
                win_q[5] <= lb0_rd;
                win_q[8] <= pix_data;
            end
        end
    end

`ifdef MEDIAN_COORD_EN
    logic [COORD_W-1:0] cx_q [SORT_LAT+1];
    logic [COORD_W-1:0] cy_q [SORT_LAT+1];
    logic [COORD_W-1:0] med_x_q, med_y_q;

    assign med_x = med_x_q;
    assign med_y = med_y_q;

    // shifts every cycle so each stage stays aligned with the matching launch bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            med_x_q <= '0;
            med_y_q <= '0;
            for (int i = 0; i <= SORT_LAT; i++) begin
                cx_q[i] <= '0;
                cy_q[i] <= '0;
            end
        end else begin
            cx_q[0] <= x_q - ONE;
            cy_q[0] <= y_q - ONE;
            for (int i = 1; i <= SORT_LAT; i++) begin
                cx_q[i] <= cx_q[i-1];
                cy_q[i] <= cy_q[i-1];
            end
            if (vpipe_q[SORT_LAT]) begin
                med_x_q <= cx_q[SORT_LAT];
                med_y_q <= cy_q[SORT_LAT];
            end
        end
    end
`endif

endmodule

// File: tb/tb_median_window_ctrl.sv
// Bench for median_window_ctrl on a 4x4 frame with a one-cycle behavioural sort unit.
module tb_median_window_ctrl;

    localparam int SZ = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int SL = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [SZ-1:0] pix_data = '0;
    logic [SZ-1:0] sort_median = '0;
    logic          busy, done, pix_ready, med_valid;
    logic [9*SZ-1:0] sort_win;
    logic [SZ-1:0] med_data;
`ifdef MEDIAN_COORD_EN
    logic [15:0]   med_x, med_y;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        int med;
        int x;
        int y;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    int   got_q[$];
    int   gx_q[$];
    int   gy_q[$];
    int   done_cnt = 0;
    int   vld_cnt = 0;
    logic [9*SZ-1:0] first_win;
    bit   first_seen;

    always #5 clk = ~clk;

    median_window_ctrl #(.SIZE(SZ), .WIDTH(W), .HEIGHT(H), .SORT_LAT(SL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .sort_win    (sort_win),
        .sort_median (sort_median),
        .med_valid   (med_valid),
        .med_data    (med_data)
`ifdef MEDIAN_COORD_EN
        ,
        .med_x       (med_x),
        .med_y       (med_y)
`endif
    );

    // Sort unit: bubble sort of the window, registered (latency 1)
    function automatic logic [SZ-1:0] sort_mid(input logic [9*SZ-1:0] w);
        logic [SZ-1:0] v [9];
        logic [SZ-1:0] t;
        for (int i = 0; i < 9; i++) v[i] = w[i*SZ +: SZ];
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    always @(posedge clk) sort_median <= sort_mid(sort_win);

    // Model median: the value with at most 4 smaller and at least 5 not-larger entries
    function automatic int model_med(input int v[9]);
        for (int i = 0; i < 9; i++) begin
            int lt, le;
            lt = 0; le = 0;
            for (int j = 0; j < 9; j++) begin
                if (v[j] < v[i]) lt++;
                if (v[j] <= v[i]) le++;
            end
            if (lt <= 4 && le >= 5) return v[i];
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (med_valid) begin
                vld_cnt++;
                got_q.push_back(int'(med_data));
`ifdef MEDIAN_COORD_EN
                gx_q.push_back(int'(med_x));
                gy_q.push_back(int'(med_y));
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_med_valid: got med_data %0d expected no output", med_data);
                end else begin
                    cur_e = exp_q.pop_front();
                    chk("med_data", med_data, cur_e.med);
`ifdef MEDIAN_COORD_EN
                    chk("med_x", med_x, cur_e.x);
                    chk("med_y", med_y, cur_e.y);
`endif
                end
            end
        end
    end

    task automatic send_pix(input int v);
        bit ok;
        int n;
        ok = 0;
        n = 0;
        pix_valid = 1'b1;
        pix_data = SZ'(v);
        while (!ok && n < 20) begin
            ok = pix_ready;
            @(posedge clk);
            #1;
            n++;
        end
        pix_valid = 1'b0;
        if (!ok) chk("pix_ready_timeout", 0, 1);
    endtask

    task automatic run_frame(input int f[16], input bit gap, input bit mid_start);
        logic [9*SZ-1:0] ew;
        exp_t le;
        bit lastv, seen;
        int d0;
        d0 = done_cnt;
        got_q.delete(); gx_q.delete(); gy_q.delete();
        first_seen = 0;
        for (int y = 1; y <= H - 2; y++)
            for (int x = 1; x <= W - 2; x++) begin
                int v[9];
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        v[r*3+c] = f[(y-1+r)*W + x-1+c];
                le.med = model_med(v); le.x = x; le.y = y;
                exp_q.push_back(le);
            end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", pix_ready, 1);
        for (int i = 0; i < W*H; i++) begin
            if (mid_start && i == 6) start = 1'b1;
            send_pix(f[i]);
            start = 1'b0;
            if (i % W >= 2 && i / W >= 2) begin
                ew = '0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        ew = (ew << SZ) | (9*SZ)'(f[(i/W-2+r)*W + i%W-2+c]);
                chk("sort_win", sort_win, ew);
                if (!first_seen) begin
                    first_win = sort_win;
                    first_seen = 1;
                end
            end
            if (gap) begin
                @(posedge clk); #1;
            end
        end
        chk("ready_in_drain", pix_ready, 0);
        seen = 0;
        lastv = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1;
            else lastv = med_valid;
        end
        chk("done_seen", seen, 1);
        chk("med_valid_before_done", lastv, 1);
        chk("busy_low_with_done", busy, 0);
        chk("med_count", got_q.size(), 4);
        chk("expected_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    task automatic chk_meds(input int a, input int b, input int c, input int d);
        int e[4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        for (int i = 0; i < 4; i++)
            chk("med_seq", (i < got_q.size()) ? got_q[i] : -1, e[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ramp[16], desc[16];
        int v0, d0;
        for (int i = 0; i < 16; i++) begin
            ramp[i] = i;
            desc[i] = 15 - i;
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_med_valid", med_valid, 0);
        chk("rst_med_data", med_data, 0);
        chk("rst_sort_win", sort_win, 0);
`ifdef MEDIAN_COORD_EN
        chk("rst_med_x", med_x, 0);
        chk("rst_med_y", med_y, 0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_pix_ready", pix_ready, 0);
        chk("idle_busy", busy, 0);

        run_frame(ramp, 0, 0);
        chk_meds(5, 6, 9, 10);
        chk("first_win", first_win, 72'h00_01_02_04_05_06_08_09_0a);
`ifdef MEDIAN_COORD_EN
        for (int i = 0; i < 4; i++) begin
            chk("coord_x_seq", (i < gx_q.size()) ? gx_q[i] : -1, (i % 2) + 1);
            chk("coord_y_seq", (i < gy_q.size()) ? gy_q[i] : -1, (i / 2) + 1);
        end
`endif

        run_frame(ramp, 1, 0);
        chk_meds(5, 6, 9, 10);

        run_frame(ramp, 0, 1);
        chk_meds(5, 6, 9, 10);
        run_frame(desc, 0, 0);
        chk_meds(10, 9, 6, 5);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) send_pix(ramp[i]);
        v0 = vld_cnt;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pix_ready", pix_ready, 0);
        chk("midrst_sort_win", sort_win, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_med_valid", vld_cnt - v0, 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_idle", busy, 0);

        run_frame(ramp, 0, 0);
        chk_meds(5, 6, 9, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/median_window_ctrl.md
# median_window_ctrl

Streaming controller that feeds the 9-input, SIZE-bit sort/median unit for the image filter. It accepts a raster-scan pixel stream and keeps two line buffers plus a 3x3 shift window. For every interior pixel it launches one 9-value window into the sort unit, then returns the median together with a valid strobe that tracks the sort unit's fixed pipeline latency.

## Interface
Parameters:
- SIZE, 8, pixel width in bits
- WIDTH, 64, pixels per line (>=3)
- HEIGHT, 64, lines per frame (>=3)
- SORT_LAT, 1, cycles from sort_win change to sort_median valid (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  begin a frame; sampled only in IDLE
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last median
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  controller accepts a pixel; a transfer occurs when pix_valid&&pix_ready
- pix_data  in  SIZE  raster-order pixel
- sort_win  out  9*SIZE  window to sort unit; MSB slice = top-left, then row-major, LSB slice = bottom-right
- sort_median  in  SIZE  median returned by sort unit
- med_valid  out  1  med_data valid, one cycle per interior pixel
- med_data  out  SIZE  registered copy of sort_median
- med_x, med_y  out  16 each  centre coordinate (MEDIAN_COORD_EN only)

## Operation
- States: IDLE, FILL, RUN, DRAIN.
- IDLE -> FILL on start. Counters x=0, y=0. Valid pipeline is cleared.
- FILL: pixels are accepted until x=1 on line 2. Line buffers and window load; no launches occur.
- FILL -> RUN on the transfer that makes the next pixel the first launch pixel.
- RUN: every transfer at (x>=2, y>=2) launches the window centred at (x-1, y-1).
  - The window register updates on the transfer edge.
  - A launch bit enters a SORT_LAT-deep shift register.
- On the transfer of (WIDTH-1, HEIGHT-1): RUN -> DRAIN.
- DRAIN: pix_ready=0. After the last launch bit emerges: done=1 for one cycle, then IDLE.
- Column shift: each transfer shifts all three window rows left by one. The new right column is {linebuf1[x], linebuf0[x], pix_data}. Then linebuf1[x] <= linebuf0[x] and linebuf0[x] <= pix_data.
- Counters: x wraps at WIDTH-1 to 0 and increments y. No launch is made for x<2, so row wrap never mixes lines.
- pix_ready = 1 in FILL/RUN, 0 in IDLE/DRAIN. Transfers are only accepted when pix_ready=1.
- start while busy is ignored.
- Output: med_valid = shift-register tail. med_data <= sort_median on that cycle and holds otherwise.
- Frame output: exactly (WIDTH-2)*(HEIGHT-2) med_valid pulses, in raster order.

## Timing
- Reset values: busy=0, done=0, pix_ready=0, med_valid=0, med_data=0, sort_win=0, med_x/med_y=0. State is IDLE and line buffers are don't-care.
- start registered: busy and pix_ready go high the cycle after start.
- Latency: transfer edge T updates sort_win. med_valid and med_data appear at edge T+SORT_LAT+1.
- done asserts the cycle after the final med_valid; busy drops together with done.
- pix_valid gaps stall the counters and window; in-flight medians still emerge on schedule.
- rst_n low mid-frame: immediate IDLE, valid pipeline cleared. No med_valid or done follows the reset.

## Configuration
- MEDIAN_COORD_EN defined: med_x and med_y ports exist. They are pipelined alongside the launch bit and equal the window centre coordinates when med_valid=1.
- Not defined: the ports and their pipeline are absent. All other behaviour is identical.

## Structure
- Package median_ctrl_pkg: state enum (IDLE, FILL, RUN, DRAIN), the window tap count 9, and the coordinate width 16.
- Sub-module median_line_buffer: a WIDTH-deep, SIZE-bit single-port read-before-write array, instantiated twice.

## Test plan
All scenarios use WIDTH=4, HEIGHT=4, SORT_LAT=1, with a real sort instance as the sort unit.
- Reset: hold rst_n=0 -> all outputs 0; pix_ready=0 after release, until start.
- Ramp frame 0..15 with pix_valid constant -> med_data sequence 5, 6, 9, 10. The first sort_win is {0,1,2,4,5,6,8,9,10}. done pulses the cycle after the 4th med_valid.
- Same frame with pix_valid toggling 1,0,1,0 -> same four medians. Exactly 4 med_valid pulses, none back-to-back with stale data.
- start pulsed mid-frame -> ignored; output matches the ramp case. The frame after done, with values 15..0, -> medians 10, 9, 6, 5.
- rst_n low after 7 transfers, then a fresh start and ramp -> no output before the restart, then 5, 6, 9, 10.
- MEDIAN_COORD_EN defined, ramp frame -> (med_x, med_y) = (1,1), (2,1), (1,2), (2,2).
